if_fetch: RTL and testbench

Instruction-fetch stage: owns the program counter, drives word addresses into the synchronous instruction memory (one-cycle registered read), and captures the returned words into a small prefetch queue. The queue feeds decode through a valid/ready handshake. Sits between the instruction memory and the decode stage. Accepts branch/jump redirects from execute, which flush all queued and in-flight fetches.

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_fetch_if.sv | 23 ++
 rtl/if_fetch_queue.sv | 51 +++++
 rtl/if_fetch.sv | 76 +++++++
 tb/tb_if_fetch.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int          WORD_WIDTH       = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    // True when one more fetch can be issued without overrunning the queue.
    function automatic logic has_credit(input int count, input logic issued,
                                        input logic deq, input int depth);
        return (count + int'(issued) - int'(deq)) < depth;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface if_fetch_if #(
    parameter int W = if_fetch_pkg::WORD_WIDTH
);
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         id_valid;
    logic         id_ready;
    logic [W-1:0] id_instr;
    logic [W-1:0] id_pc;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO holding {instruction, pc} pairs; flush empties it in one cycle.
module fetch_queue
    import if_fetch_pkg::*;
#(
    parameter  int W     = WORD_WIDTH,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_instr,
    input  logic [W-1:0]  push_pc,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [W-1:0]  head_instr,
    output logic [W-1:0]  head_pc
);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_instr, push_pc};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_valid              = (count != '0);
    assign {head_instr, head_pc}   = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, credit-based issue to a one-cycle memory, redirect squash.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int           W        = WORD_WIDTH,
    parameter logic [W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int           DEPTH    = 2
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);

    localparam int           CW      = $clog2(DEPTH) + 1;
    localparam logic [W-1:0] PC_MASK = ~W'(INSTR_BYTES - 1);
    localparam logic [W-1:0] PC_INC  = W'(INSTR_BYTES);

    logic [W-1:0]  fetch_pc_p0;
    logic          issued_p1;
    logic [W-1:0]  issued_pc_p1;
    logic          squash_p1;
    logic [CW-1:0] count;
    logic          vld_head;
    logic [W-1:0]  head_instr;
    logic [W-1:0]  head_pc;
    logic          deq;
    logic          issue;
    logic          push;

    assign bus.imem_addr = fetch_pc_p0;
    assign deq   = vld_head & bus.id_ready;
    assign issue = rst & !bus.redirect_valid & has_credit(int'(count), issued_p1, deq, DEPTH);
    assign push  = issued_p1 & !squash_p1;

    // p0 -> p1: address issued this cycle, response captured next cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_p0 <= RESET_PC;
            issued_p1   <= 1'b0;
            squash_p1   <= 1'b0;
        end else begin
            issued_p1 <= issue;
            squash_p1 <= bus.redirect_valid & issued_p1;
            if (bus.redirect_valid)
                fetch_pc_p0 <= bus.redirect_pc & PC_MASK;
            else if (issue)
                fetch_pc_p0 <= fetch_pc_p0 + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) issued_pc_p1 <= fetch_pc_p0;
    end

    fetch_queue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_instr (bus.imem_data),
        .push_pc    (issued_pc_p1),
        .pop        (deq),
        .count      (count),
        .head_valid (vld_head),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    assign bus.id_valid = vld_head;
    assign bus.id_instr = head_instr;
    assign bus.id_pc    = head_pc;

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: expected instruction stream scoreboard plus timing checks.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          W      = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    if_fetch_if #(.W(W)) bus ();

    if_fetch #(
        .W        (W),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Synchronous memory: data for the address seen at an edge appears after it.
    always @(posedge clk) bus.imem_data <= word_at(bus.imem_addr);

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_next = RST_PC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: cycles since the last reset/redirect cycle drive the timing expectations.
    int          since      = 0;
    logic        evt_reset  = 1'b1;
    logic [31:0] evt_target = RST_PC;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;

    initial begin
        forever begin
            int k;
            logic [31:0] e;
            @(negedge clk);
            k = since + 1;
            if (k == 1 || k == 2) check("gap_valid", 32'(bus.id_valid), 32'd0);
            if (k == 1 && evt_reset) begin
                check("rst_id_pc", bus.id_pc, 32'd0);
                check("rst_id_instr", bus.id_instr, 32'd0);
                check("rst_imem_addr", bus.imem_addr, RST_PC);
            end
            if (k == 1 && !evt_reset) check("redir_imem_addr", bus.imem_addr, evt_target);
            if (k == 3) begin
                check("first_valid", 32'(bus.id_valid), 32'd1);
                check("first_pc", bus.id_pc, evt_target);
            end
            if (k >= 2 && prev_valid) check("no_bubble", 32'(bus.id_valid), 32'd1);
            if (k >= 2 && prev_valid && !prev_ready) begin
                check("hold_pc", bus.id_pc, prev_pc);
                check("hold_instr", bus.id_instr, prev_instr);
            end
            if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_empty: got pc %h, expected no delivery", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_pc", bus.id_pc, e);
                    check("stream_instr", bus.id_instr, word_at(e));
                end
            end
            if (!rst) begin
                evt_reset  = 1'b1;
                evt_target = RST_PC;
                since      = 0;
            end else if (bus.redirect_valid) begin
                evt_reset  = 1'b0;
                evt_target = bus.redirect_pc & ~32'h3;
                since      = 0;
            end else begin
                since = (k > 1000) ? 1000 : k;
            end
            prev_valid = bus.id_valid;
            prev_ready = bus.id_ready;
            prev_pc    = bus.id_pc;
            prev_instr = bus.id_instr;
        end
    end

    // One cycle of stimulus; afterwards the expected stream is restarted or topped up.
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst                = r;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            sb_next = RST_PC;
        end else if (rv) begin
            exp_q.delete();
            sb_next = rpc & ~32'h3;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(sb_next);
            sb_next = sb_next + 32'd4;
        end
    endtask

    initial begin
        logic        rr, rdy, rv;
        logic [31:0] rpc;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        repeat (3)  step(1'b0, 1'b1, 1'b0, '0);
        repeat (12) step(1'b1, 1'b1, 1'b0, '0);

        // fresh start, then stall with pc 8 at the head
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (4)  step(1'b1, 1'b1, 1'b0, '0);
        repeat (5)  step(1'b1, 1'b0, 1'b0, '0);
        repeat (8)  step(1'b1, 1'b1, 1'b0, '0);

        // redirect while the queue is full
        repeat (4)  step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h40);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);

        step(1'b1, 1'b1, 1'b1, 32'h43);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);

        step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);

        // reset mid-stream with a fetch in flight
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (8)  step(1'b1, 1'b1, 1'b0, '0);

        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);

        for (int i = 0; i < 2000; i++) begin
            rr  = ($urandom_range(0, 99) >= 1);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            step(rr, rdy, rv, rpc);
        end
        repeat (4) step(1'b1, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
